osc_pulse_bank: RTL and testbench
=================================

OSC_PULSE_BANK -- requirements
Module: osc_pulse_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of pulse oscillator channels (1..16).
REQ-002 SHALL have parameter PHASE_W, default 16, meaning width of the phase accumulator, frequency word and pulse-width word.
REQ-003 SHALL have parameter SAMPLE_W, default 16, meaning signed width of volume and output sample.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port sample_tick, input, 1, meaning a one-cycle strobe that requests one mixed sample.
REQ-007 SHALL have port en, input, NUM_CH, meaning per-channel enable.
REQ-008 SHALL have port frequency, input, NUM_CH*PHASE_W, meaning the per-channel phase increment per sample (channel c at bits [c*PHASE_W +: PHASE_W]).
REQ-009 SHALL have port pulse_width, input, NUM_CH*PHASE_W, meaning the per-channel high-phase threshold.
REQ-010 SHALL have port volume, input, NUM_CH*SAMPLE_W, meaning the per-channel signed amplitude.
REQ-011 SHALL have port sync_en, input, NUM_CH, meaning per-channel hard-sync enable (bit 0 ignored).
REQ-012 SHALL have port overrun_clr, input, 1, meaning a strobe that clears overrun.
REQ-013 SHALL have port out_sample, output, SAMPLE_W signed, meaning the mixed sample.
REQ-014 SHALL have port out_valid, output, 1, meaning out_sample is valid.
REQ-015 SHALL have port out_ready, input, 1, meaning the consumer accepts out_sample.
REQ-016 SHALL have port busy, output, 1, meaning a mix pass is in progress.
REQ-017 SHALL have port overrun, output, 1, meaning a sticky flag set when a tick is dropped.

Function
REQ-018 SHALL implement FSM IDLE -> RUN -> OUT -> IDLE: sample_tick in IDLE with out_valid=0 enters RUN with channel index 0; RUN lasts exactly NUM_CH cycles, processing channel c in RUN cycle c; after the last channel the FSM enters OUT, with out_valid=1 on cycle tick+NUM_CH+1.
REQ-019 SHALL, per RUN cycle and for enabled channel c, set phase[c] = (phase[c] + frequency[c]) mod 2^PHASE_W, with wrap[c] = carry out, sampling the channel's inputs in that cycle only.
REQ-020 SHALL, for channel c, contribute +volume[c] when the updated phase < pulse_width[c], and -volume[c] otherwise; -(most negative value) SHALL saturate to the most positive value; pulse_width=0 gives always -volume.
REQ-021 SHALL, for a disabled channel, contribute 0, clear phase[c] to 0, and clear wrap[c].
REQ-022 SHALL accumulate contributions at SAMPLE_W+clog2(NUM_CH)+1 bits without overflow, then saturate the sum to the signed SAMPLE_W range when loading out_sample.
REQ-023 SHALL hold out_sample and out_valid stable in OUT until out_valid && out_ready, then return to IDLE the next cycle with out_valid=0.
REQ-024 SHALL, on sample_tick while busy=1 or out_valid=1, drop the tick, set overrun=1, and leave out_sample unchanged.
REQ-025 SHALL clear overrun on overrun_clr; a simultaneous drop SHALL win and leave overrun=1.
REQ-026 SHALL drive busy=1 exactly during RUN cycles.

Reset
REQ-027 SHALL, on rst asserted at any time including mid-pass, immediately force state IDLE, all phases 0, out_sample 0, out_valid 0, busy 0, overrun 0, and the accumulator 0.

Configuration
REQ-028 SHALL, with macro OSC_PULSE_BANK_SYNC_EN defined, set phase[c] to 0 (instead of the REQ-019 update) for c>=1 when sync_en[c]=1 and wrap[c-1] occurred in the same pass; without the macro, sync_en SHALL be present but ignored and phases always update per REQ-019.

Verification
REQ-029 SHALL cover: ch0 only, freq=0x4000, pw=0x8000, vol=1000, four ticks -> samples +1000, -1000, -1000, +1000.
REQ-030 SHALL cover: all 4 channels, freq=1, pw=0xFFFF, vol=20000 -> 32767; vol=-20000 -> -32768.
REQ-031 SHALL cover: tick at cycle 0 -> busy on cycles 1-4, out_valid on cycle 5; with out_ready=0, a second tick -> overrun=1 and out_sample unchanged; overrun_clr -> overrun=0.
REQ-032 SHALL cover: rst asserted on RUN cycle 2 -> all outputs 0 immediately; the next tick produces a sample as if from power-up phases.
REQ-033 SHALL cover: macro defined, ch0 freq=0x8000, ch1 freq=0x3000, pw1=0x4000, sync_en[1]=1 -> ch1 phases 0x3000, 0x0000, 0x3000, 0x0000; without the macro -> 0x3000, 0x6000, 0x9000, 0xC000.
REQ-034 SHALL cover: ch0 pw=0, vol=500 -> constant -500; en[0] dropped -> 0, then re-enabled with phase restarting from 0.

Source files
------------

// File: rtl/osc_pulse_bank.sv
// Bank of pulse oscillators mixed into one saturated sample per tick.
// Define OSC_PULSE_BANK_SYNC_EN to enable per-channel hard sync.
module osc_pulse_bank #(
    parameter int NUM_CH   = 4,
    parameter int PHASE_W  = 16,
    parameter int SAMPLE_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic [NUM_CH-1:0]            en,
    input  logic [NUM_CH*PHASE_W-1:0]    frequency,
    input  logic [NUM_CH*PHASE_W-1:0]    pulse_width,
    input  logic [NUM_CH*SAMPLE_W-1:0]   volume,
    input  logic [NUM_CH-1:0]            sync_en,
    input  logic                         overrun_clr,
    output logic signed [SAMPLE_W-1:0]   out_sample,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         overrun
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_CH) + 1;
    localparam int EXT_W = ACC_W - SAMPLE_W + 1;

    localparam logic signed [SAMPLE_W-1:0] S_MAX =
        {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] S_MIN =
        {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] A_MAX =
        {{EXT_W{1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] A_MIN =
        {{EXT_W{1'b1}}, {(SAMPLE_W-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc;
    logic [PHASE_W-1:0]        phase_q [NUM_CH];
    logic                      wrap_q  [NUM_CH];

    logic [PHASE_W-1:0]        freq_a  [NUM_CH];
    logic [PHASE_W-1:0]        pw_a    [NUM_CH];
    logic signed [SAMPLE_W-1:0] vol_a  [NUM_CH];

    logic [PHASE_W-1:0]        cur_freq;
    logic [PHASE_W-1:0]        cur_pw;
    logic signed [SAMPLE_W-1:0] cur_vol;
    logic                      cur_en;
    logic [PHASE_W:0]          sum;
    logic                      sync_hit;
    logic [PHASE_W-1:0]        new_phase;
    logic                      new_wrap;
    logic signed [SAMPLE_W-1:0] neg_vol;
    logic signed [SAMPLE_W-1:0] contrib;
    logic signed [ACC_W-1:0]   contrib_x;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [SAMPLE_W-1:0] sat_sum;
    logic                      drop;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            freq_a[c] = frequency[c*PHASE_W +: PHASE_W];
            pw_a[c]   = pulse_width[c*PHASE_W +: PHASE_W];
            vol_a[c]  = volume[c*SAMPLE_W +: SAMPLE_W];
        end
    end

`ifdef OSC_PULSE_BANK_SYNC_EN
    logic [IDX_W-1:0] prev;
    assign prev     = idx - 1'b1;
    // Previous channel ran one cycle earlier in this same pass.
    assign sync_hit = (idx != '0) && sync_en[idx] && wrap_q[prev];
`else
    logic unused_sync;
    assign unused_sync = ^sync_en;
    assign sync_hit    = 1'b0;
`endif

    always_comb begin
        cur_freq  = freq_a[idx];
        cur_pw    = pw_a[idx];
        cur_vol   = vol_a[idx];
        cur_en    = en[idx];
        sum       = {1'b0, phase_q[idx]} + {1'b0, cur_freq};
        new_wrap  = sum[PHASE_W];
        new_phase = sync_hit ? '0 : sum[PHASE_W-1:0];
        neg_vol   = (cur_vol == S_MIN) ? S_MAX : -cur_vol;
        if (!cur_en)
            contrib = '0;
        else if (new_phase < cur_pw)
            contrib = cur_vol;
        else
            contrib = neg_vol;
        contrib_x = contrib;
        acc_next  = acc + contrib_x;
        if (acc_next > A_MAX)
            sat_sum = S_MAX;
        else if (acc_next < A_MIN)
            sat_sum = S_MIN;
        else
            sat_sum = acc_next[SAMPLE_W-1:0];
    end

    assign drop = sample_tick && (busy || out_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                phase_q[c] <= '0;
                wrap_q[c]  <= 1'b0;
            end
        end else begin
            if (drop)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (sample_tick) begin
                        state <= RUN;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    phase_q[idx] <= cur_en ? new_phase : '0;
                    wrap_q[idx]  <= cur_en ? new_wrap : 1'b0;
                    acc          <= acc_next;
                    if (idx == LAST) begin
                        state      <= OUT;
                        busy       <= 1'b0;
                        out_valid  <= 1'b1;
                        out_sample <= sat_sum;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_osc_pulse_bank.sv
// Directed bench for osc_pulse_bank: mixing, saturation, timing,
// overrun, async reset, hard sync and enable behaviour.
module tb_osc_pulse_bank;

    logic               clk = 1'b0;
    logic               rst;
    logic               sample_tick;
    logic [3:0]         en;
    logic [63:0]        frequency;
    logic [63:0]        pulse_width;
    logic [63:0]        volume;
    logic [3:0]         sync_en;
    logic               overrun_clr;
    logic signed [15:0] out_sample;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               overrun;

    int n_pass = 0;
    int n_tot  = 0;
    int s;

    osc_pulse_bank dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .en          (en),
        .frequency   (frequency),
        .pulse_width (pulse_width),
        .volume      (volume),
        .sync_en     (sync_en),
        .overrun_clr (overrun_clr),
        .out_sample  (out_sample),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tot++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_ch(input int c, input bit e, input int f,
                          input int pw, input int v);
        en[c]                  = e;
        frequency[c*16 +: 16]  = f[15:0];
        pulse_width[c*16 +: 16] = pw[15:0];
        volume[c*16 +: 16]     = v[15:0];
    endtask

    task automatic do_reset();
        en          = '0;
        frequency   = '0;
        pulse_width = '0;
        volume      = '0;
        sync_en     = '0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !out_valid; i++)
            @(negedge clk);
        if (!out_valid)
            check({tag, "_timeout"}, int'(out_valid), 1);
    endtask

    task automatic sample_once(input string tag, output int v);
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        wait_valid(tag);
        v = out_sample;
        out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
    endtask

    initial begin
        int exp029 [4];
        int exp033 [4];
        exp029 = '{1000, -1000, -1000, 1000};
`ifdef OSC_PULSE_BANK_SYNC_EN
        exp033 = '{100, 100, 100, 100};
`else
        exp033 = '{100, -100, -100, -100};
`endif
        rst         = 1'b1;
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        out_ready   = 1'b0;
        en          = '0;
        frequency   = '0;
        pulse_width = '0;
        volume      = '0;
        sync_en     = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_sample", int'(out_sample), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        rst = 1'b0;

        // single channel square at quarter rate
        set_ch(0, 1, 'h4000, 'h8000, 1000);
        for (int i = 0; i < 4; i++) begin
            sample_once("sq", s);
            check($sformatf("sq%0d", i), s, exp029[i]);
        end

        // four channels summed past the rails
        do_reset();
        for (int c = 0; c < 4; c++)
            set_ch(c, 1, 1, 'hFFFF, 20000);
        sample_once("satp", s);
        check("sat_pos", s, 32767);
        for (int c = 0; c < 4; c++)
            set_ch(c, 1, 1, 'hFFFF, -20000);
        sample_once("satn", s);
        check("sat_neg", s, -32768);

        // timing, hold and overrun handling
        do_reset();
        set_ch(0, 1, 'h4000, 'h8000, 1000);
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        check("t1_busy", int'(busy), 1);
        check("t1_valid", int'(out_valid), 0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("t%0d_busy", i), int'(busy), 1);
        end
        @(negedge clk);
        check("t5_busy", int'(busy), 0);
        check("t5_valid", int'(out_valid), 1);
        check("t5_sample", int'(out_sample), 1000);
        @(negedge clk);
        check("hold_valid", int'(out_valid), 1);
        sample_tick = 1'b1;
        @(negedge clk) sample_tick = 1'b0;
        check("ovr_set", int'(overrun), 1);
        check("ovr_sample", int'(out_sample), 1000);
        check("ovr_valid", int'(out_valid), 1);
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        check("ovr_race", int'(overrun), 1);
        overrun_clr = 1'b1;
        @(negedge clk) overrun_clr = 1'b0;
        check("ovr_clr", int'(overrun), 0);
        out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
        check("acc_valid", int'(out_valid), 0);
        check("acc_busy", int'(busy), 0);
        // tick landing during RUN is dropped too
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk);
        @(negedge clk) sample_tick = 1'b0;
        check("busy_drop", int'(overrun), 1);
        wait_valid("bd");
        check("bd_sample", int'(out_sample), -1000);
        out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;

        // async reset in RUN cycle 2
        do_reset();
        set_ch(0, 1, 'h4000, 'h8000, 1000);
        sample_once("pre", s);
        check("pre_rst", s, 1000);
        @(negedge clk) sample_tick = 1'b1;
        @(negedge clk);
        @(negedge clk) sample_tick = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_sample", int'(out_sample), 0);
        check("mid_busy", int'(busy), 0);
        check("mid_valid", int'(out_valid), 0);
        check("mid_overrun", int'(overrun), 0);
        @(negedge clk) rst = 1'b0;
        sample_once("post", s);
        check("post_rst", s, 1000);

        // hard sync from channel 0 wrap
        do_reset();
        set_ch(0, 1, 'h8000, 0, 0);
        set_ch(1, 1, 'h3000, 'h4000, 100);
        sync_en = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            sample_once("sync", s);
            check($sformatf("sync%0d", i), s, exp033[i]);
        end

        // zero pulse width, disable and re-enable
        do_reset();
        set_ch(0, 1, 'h4000, 0, 500);
        sample_once("pw0", s);
        check("pw0_a", s, -500);
        sample_once("pw0", s);
        check("pw0_b", s, -500);
        en[0] = 1'b0;
        sample_once("dis", s);
        check("dis", s, 0);
        set_ch(0, 1, 'h4000, 'h8000, 500);
        sample_once("reen", s);
        check("reen", s, 500);
        set_ch(0, 1, 'h4000, 0, -32768);
        sample_once("negmin", s);
        check("neg_min", s, 32767);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
